// File: rtl/pe_multicast_ctrl.sv
// pe_multicast_ctrl
// Sending end of the PE enable/ready interface. It snoops the shared
// global-buffer bus and accepts packets whose tag matches the configured
// PE ID, or the all-ones broadcast tag. Accepted packets are queued in a
// small FIFO and handed to the PE one per cycle while the PE is ready.
// There is no push-through when full and no same-cycle bypass.

module pe_multicast_ctrl #(
  parameter int BITWIDTH   = 16,
  parameter int ID_WIDTH   = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rstb,
  // ID configuration
  input  logic                           cfg_load,
  input  logic [ID_WIDTH-1:0]            cfg_id,
  input  logic                           flush,
  // Global-buffer bus
  input  logic                           bus_valid,
  input  logic [ID_WIDTH-1:0]            bus_tag,
  input  logic signed [BITWIDTH-1:0]     bus_ifmap,
  input  logic signed [BITWIDTH-1:0]     bus_filter,
  input  logic signed [BITWIDTH-1:0]     bus_psum,
  input  logic [2:0]                     bus_control,
  output logic                           bus_ready,
  // PE side
  input  logic                           pe_ready,
  output logic                           pe_enable,
  output logic signed [BITWIDTH-1:0]     pe_ifmap,
  output logic signed [BITWIDTH-1:0]     pe_filter,
  output logic signed [BITWIDTH-1:0]     pe_psum,
  output logic [2:0]                     pe_control,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]       FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [ID_WIDTH-1:0] BCAST_TAG = '1;

  // One FIFO entry: the full packet as presented on the bus.
  typedef struct packed {
    logic signed [BITWIDTH-1:0] ifmap;
    logic signed [BITWIDTH-1:0] filter;
    logic signed [BITWIDTH-1:0] psum;
    logic [2:0]                 control;
  } entry_t;

  // ID register
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic                id_valid_q, id_valid_d;

  // FIFO state
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [FIFO_DEPTH];

  // Handshake decode
  logic   match;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  entry_t wr_entry;
  entry_t head;

  // Tag match, FIFO status and the bus/PE handshakes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    match     = 1'b0;
    full      = 1'b0;
    empty     = 1'b0;
    bus_ready = 1'b0;
    pe_enable = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;

    // An unconfigured controller matches nothing, not even broadcast.
    match = id_valid_q && ((bus_tag == id_q) || (bus_tag == BCAST_TAG));
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);

    // Non-matching packets are always acknowledged and dropped. A matching
    // packet is refused while full even if a pop happens this cycle, so
    // pe_ready never reaches bus_ready.
    bus_ready = flush ? 1'b0 : (!match || !full);
    pe_enable = !empty && pe_ready && !flush;

    push = bus_valid && bus_ready && match;
    pop  = pe_enable;
  end

  // Packet assembly for the write port.
  always_comb begin
    wr_entry         = '0;
    wr_entry.ifmap   = bus_ifmap;
    wr_entry.filter  = bus_filter;
    wr_entry.psum    = bus_psum;
    wr_entry.control = bus_control;
  end

  // Next ID register value; a new ID is used for matching from the next cycle.
  always_comb begin
    id_d       = id_q;
    id_valid_d = id_valid_q;
    if (cfg_load) begin
      id_d       = cfg_id;
      id_valid_d = 1'b1;
    end
  end

  // Next pointer and occupancy; flush wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth, so pointers wrap by natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      id_q       <= '0;
      id_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      id_q       <= id_d;
      id_valid_q <= id_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Packet storage, written at the tail on an accepted push.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      // NOTE: storage is reset on purpose so a drained or flushed FIFO never exposes stale packets; it is only a few flops.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Head entry to the PE, forced to zero while empty.
  always_comb begin
    head = '0;
    if (count_q != '0) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign pe_ifmap   = head.ifmap;
  assign pe_filter  = head.filter;
  assign pe_psum    = head.psum;
  assign pe_control = head.control;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_pe_multicast_ctrl.sv
// tb_pe_multicast_ctrl
// Directed bench for pe_multicast_ctrl. A queue-based model of the packet
// filter and FIFO is compared against the DUT on every falling edge, and
// directed sequences pin the model with hand-computed values.

module tb_pe_multicast_ctrl;

  localparam int BW    = 16;
  localparam int IW    = 5;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rstb;
  logic          cfg_load;
  logic [IW-1:0] cfg_id;
  logic          flush;
  logic          bus_valid;
  logic [IW-1:0] bus_tag;
  logic [BW-1:0] bus_ifmap;
  logic [BW-1:0] bus_filter;
  logic [BW-1:0] bus_psum;
  logic [2:0]    bus_control;
  logic          bus_ready;
  logic          pe_ready;
  logic          pe_enable;
  logic [BW-1:0] pe_ifmap;
  logic [BW-1:0] pe_filter;
  logic [BW-1:0] pe_psum;
  logic [2:0]    pe_control;
  logic [2:0]    fifo_count;

  pe_multicast_ctrl #(
    .BITWIDTH  (BW),
    .ID_WIDTH  (IW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .cfg_load   (cfg_load),
    .cfg_id     (cfg_id),
    .flush      (flush),
    .bus_valid  (bus_valid),
    .bus_tag    (bus_tag),
    .bus_ifmap  (bus_ifmap),
    .bus_filter (bus_filter),
    .bus_psum   (bus_psum),
    .bus_control(bus_control),
    .bus_ready  (bus_ready),
    .pe_ready   (pe_ready),
    .pe_enable  (pe_enable),
    .pe_ifmap   (pe_ifmap),
    .pe_filter  (pe_filter),
    .pe_psum    (pe_psum),
    .pe_control (pe_control),
    .fifo_count (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [BW-1:0] ifmap;
    logic [BW-1:0] filter;
    logic [BW-1:0] psum;
    logic [2:0]    ctrl;
  } pkt_t;

  pkt_t          m_q[$];
  logic [IW-1:0] m_id       = '0;
  logic          m_id_valid = 1'b0;

  function automatic logic m_match();
    return m_id_valid && (bus_tag == m_id || bus_tag == {IW{1'b1}});
  endfunction

  function automatic logic m_bus_ready();
    if (flush) return 1'b0;
    return !m_match() || (m_q.size() < DEPTH);
  endfunction

  function automatic logic m_pe_enable();
    return (m_q.size() > 0) && pe_ready && !flush;
  endfunction

  function automatic pkt_t m_head();
    pkt_t z;
    z = '0;
    if (m_q.size() > 0) z = m_q[0];
    return z;
  endfunction

  // Model state update: async clear, otherwise one bus/PE transaction per edge.
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_q.delete();
      m_id       = '0;
      m_id_valid = 1'b0;
    end else begin
      logic do_push;
      logic do_pop;
      pkt_t p;
      do_push = bus_valid && m_bus_ready() && m_match();
      do_pop  = m_pe_enable();
      p       = '{ifmap: bus_ifmap, filter: bus_filter, psum: bus_psum, ctrl: bus_control};
      if (flush) m_q.delete();
      else begin
        if (do_pop)  void'(m_q.pop_front());
        if (do_push) m_q.push_back(p);
      end
      if (cfg_load) begin
        m_id       = cfg_id;
        m_id_valid = 1'b1;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    pkt_t h;
    h = m_head();
    check("bus_ready",  32'(bus_ready),  32'(m_bus_ready()));
    check("pe_enable",  32'(pe_enable),  32'(m_pe_enable()));
    check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check("pe_ifmap",   32'(pe_ifmap),   32'(h.ifmap));
    check("pe_filter",  32'(pe_filter),  32'(h.filter));
    check("pe_psum",    32'(pe_psum),    32'(h.psum));
    check("pe_control", 32'(pe_control), 32'(h.ctrl));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [IW-1:0] tag, input logic [BW-1:0] ifm,
                     input logic [BW-1:0] flt, input logic [BW-1:0] ps,
                     input logic [2:0] ctl);
    bus_valid   = 1'b1;
    bus_tag     = tag;
    bus_ifmap   = ifm;
    bus_filter  = flt;
    bus_psum    = ps;
    bus_control = ctl;
  endtask

  task automatic idle_bus();
    bus_valid   = 1'b0;
    bus_tag     = '0;
    bus_ifmap   = '0;
    bus_filter  = '0;
    bus_psum    = '0;
    bus_control = '0;
  endtask

  task automatic configure(input logic [IW-1:0] id);
    cfg_load = 1'b1;
    cfg_id   = id;
    step();
    cfg_load = 1'b0;
  endtask

  initial begin
    int tags[4];
    int seen[$];

    rstb     = 1'b1;
    cfg_load = 1'b0;
    cfg_id   = '0;
    flush    = 1'b0;
    pe_ready = 1'b0;
    idle_bus();
    #1 rstb = 1'b0;
    #11 rstb = 1'b1;
    step();

    // Reset values
    check("rst_bus_ready",  32'(bus_ready),  32'd1);
    check("rst_pe_enable",  32'(pe_enable),  32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);

    // Unconfigured: tag 5 is discarded
    pe_ready = 1'b1;
    put(5'd5, 16'd9, 16'd9, 16'd9, 3'b001);
    #1 check("uncfg_bus_ready", 32'(bus_ready), 32'd1);
    step();
    check("uncfg_count", 32'(fifo_count), 32'd0);

    // Configure id 5, then one packet appears next cycle
    idle_bus();
    configure(5'd5);
    put(5'd5, 16'd3, 16'hFFFE, 16'd7, 3'b010);
    step();
    idle_bus();
    check("t1_pe_enable",  32'(pe_enable),  32'd1);
    check("t1_pe_ifmap",   32'(pe_ifmap),   32'h0003);
    check("t1_pe_filter",  32'(pe_filter),  32'hFFFE);
    check("t1_pe_psum",    32'(pe_psum),    32'h0007);
    check("t1_pe_control", 32'(pe_control), 32'd2);
    step();
    check("t1_drained", 32'(fifo_count), 32'd0);

    // Filtering: tags 4, 31, 5, 6 back to back
    tags = '{4, 31, 5, 6};
    for (int i = 0; i < 7; i++) begin
      if (i < 4) put(IW'(tags[i]), BW'(100 + i), 16'd0, 16'd0, 3'd0);
      else idle_bus();
      #1;
      if (i < 4) check($sformatf("filt_bus_ready_%0d", i), 32'(bus_ready), 32'd1);
      if (pe_enable) seen.push_back(int'(pe_ifmap));
      step();
    end
    check("filt_pulses", 32'(seen.size()), 32'd2);
    if (seen.size() == 2) begin
      check("filt_first",  32'(seen[0]), 32'd101);
      check("filt_second", 32'(seen[1]), 32'd102);
    end

    // Backpressure / full
    configure(5'd2);
    pe_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      put(5'd2, BW'(200 + i), BW'(i), 16'd0, 3'd1);
      #1 check($sformatf("full_bus_ready_%0d", i), 32'(bus_ready), (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    check("full_count", 32'(fifo_count), 32'd4);
    put(5'd3, 16'd999, 16'd0, 16'd0, 3'd0);
    #1 check("full_other_tag", 32'(bus_ready), 32'd1);
    step();
    idle_bus();
    pe_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("drain_en_%0d", i), 32'(pe_enable), 32'd1);
      check($sformatf("drain_ifmap_%0d", i), 32'(pe_ifmap), 32'(200 + i));
      step();
    end
    check("drain_count", 32'(fifo_count), 32'd0);

    // Concurrent push/pop at count 2
    pe_ready = 1'b0;
    put(5'd2, 16'd300, 16'd0, 16'd0, 3'd0);
    step();
    put(5'd2, 16'd301, 16'd0, 16'd0, 3'd0);
    step();
    idle_bus();
    check("cc_count2", 32'(fifo_count), 32'd2);
    pe_ready = 1'b1;
    put(5'd2, 16'd302, 16'd0, 16'd0, 3'd0);
    #1;
    check("cc_en",    32'(pe_enable), 32'd1);
    check("cc_ifmap", 32'(pe_ifmap),  32'd300);
    check("cc_ready", 32'(bus_ready), 32'd1);
    step();
    check("cc_count_hold", 32'(fifo_count), 32'd2);
    pe_ready = 1'b0;
    put(5'd2, 16'd303, 16'd0, 16'd0, 3'd0);
    step();
    put(5'd2, 16'd304, 16'd0, 16'd0, 3'd0);
    step();
    check("cc_count4", 32'(fifo_count), 32'd4);
    pe_ready = 1'b1;
    put(5'd2, 16'd305, 16'd0, 16'd0, 3'd0);
    #1;
    check("cc_full_refuse", 32'(bus_ready), 32'd0);
    check("cc_full_pop",    32'(pe_enable), 32'd1);
    check("cc_full_head",   32'(pe_ifmap),  32'd301);
    step();
    check("cc_count3", 32'(fifo_count), 32'd3);
    pe_ready = 1'b0;
    idle_bus();
    step();

    // Flush at count 3 with a matching packet and a ready PE
    flush    = 1'b1;
    pe_ready = 1'b1;
    put(5'd2, 16'd400, 16'd0, 16'd0, 3'd0);
    #1;
    check("fl_bus_ready", 32'(bus_ready), 32'd0);
    check("fl_pe_enable", 32'(pe_enable), 32'd0);
    step();
    flush    = 1'b0;
    pe_ready = 1'b0;
    idle_bus();
    #1;
    check("fl_count",   32'(fifo_count), 32'd0);
    check("fl_ifmap",   32'(pe_ifmap),   32'd0);
    check("fl_psum",    32'(pe_psum),    32'd0);
    check("fl_control", 32'(pe_control), 32'd0);
    check("fl_enable",  32'(pe_enable),  32'd0);
    step();

    // Async reset mid-stream at count 3
    configure(5'd5);
    for (int i = 0; i < 3; i++) begin
      put(5'd5, BW'(500 + i), 16'd0, 16'd0, 3'd0);
      step();
    end
    idle_bus();
    check("ar_count3", 32'(fifo_count), 32'd3);
    #1 pe_ready = 1'b1;
    #1 check("ar_pre_en", 32'(pe_enable), 32'd1);
    rstb = 1'b0;
    #1;
    check("ar_en",    32'(pe_enable),  32'd0);
    check("ar_count", 32'(fifo_count), 32'd0);
    check("ar_ifmap", 32'(pe_ifmap),   32'd0);
    pe_ready = 1'b0;
    step();
    #2 rstb = 1'b1;
    step();
    put(5'd5, 16'd600, 16'd0, 16'd0, 3'd0);
    #1 check("ar_tag5_ready", 32'(bus_ready), 32'd1);
    step();
    idle_bus();
    check("ar_tag5_dropped", 32'(fifo_count), 32'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
